spi_mem_ctrl: RTL
=================

SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

Interface
REQ-001 Parameter CMD_READ, default 8'h03: SPI SRAM read opcode.
REQ-002 Parameter CMD_WRITE, default 8'h02: SPI SRAM write opcode.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 mem_addr  in  16  CPU byte address.
REQ-007 mem_data_out  in  8  CPU write data.
REQ-008 mem_read  in  1  CPU read strobe.
REQ-009 mem_write  in  1  CPU write strobe.
REQ-010 mem_req  in  1  CPU access request, level.
REQ-011 mem_ready  out  1  one-cycle completion pulse to CPU.
REQ-012 mem_data_in  out  8  registered read data to CPU.
REQ-013 spi_cs_n  out  1  SRAM chip select, active low.
REQ-014 spi_sclk  out  1  SPI clock, mode 0, idle low.
REQ-015 spi_mosi  out  1  serial data to SRAM, MSB first.
REQ-016 spi_miso  in  1  serial data from SRAM.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, SHIFT, DONE; SHIFT covers 32 bits: command[7:0], address[15:0], data[7:0], all MSB first.
REQ-019 In IDLE with mem_req=1, the block SHALL latch mem_addr, mem_data_out and the direction, and enter SHIFT on that edge.
REQ-020 Direction: mem_write=1 selects write (priority over mem_read); otherwise the access is a read, including when both strobes are 0.
REQ-021 Each bit SHALL take 2 clk: phase 0 sclk=0 with mosi stable, phase 1 sclk=1; spi_sclk toggles every clk in SHIFT, so SCLK = clk/2.
REQ-022 spi_mosi SHALL change only on edges where spi_sclk goes 1->0, or on SHIFT entry.
REQ-023 On reads, spi_miso SHALL be sampled on each of the 8 data-bit edges where spi_sclk goes 0->1.
REQ-024 During read data bits, spi_mosi SHALL be 0.
REQ-025 A 5-bit bit counter plus 1-bit phase SHALL track SHIFT; after bit 31 phase 1 (64 clk in SHIFT) the FSM enters DONE.
REQ-026 In DONE, spi_cs_n=1, spi_sclk=0, mem_ready=1 for exactly one cycle; next state IDLE unconditionally.
REQ-027 Latency: mem_ready SHALL be high exactly 65 clk after the edge that accepted the request.
REQ-028 mem_data_in SHALL update at the DONE entry edge for reads only, hold its value otherwise, and be valid while mem_ready=1.
REQ-029 Writes SHALL leave mem_data_in unchanged.
REQ-030 spi_cs_n SHALL be 0 in SHIFT and 1 in IDLE and DONE, giving a minimum CS-high time of 2 clk between transactions.
REQ-031 Input changes on mem_addr, mem_data_out or the strobes during SHIFT SHALL NOT affect the transaction in flight.
REQ-032 mem_req held high in the IDLE cycle following DONE SHALL start a new transaction; the CPU control deasserts mem_req in the cycle after it samples mem_ready when no further access is wanted.
REQ-033 mem_req ignored outside IDLE; no queueing.

Reset
REQ-034 On reset: state IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, mem_ready=0, busy=0, mem_data_in=8'h00, counter 0.
REQ-035 Reset asserted mid-SHIFT SHALL abort: the next cycle shows spi_cs_n=1 and spi_sclk=0; no mem_ready is issued, and mem_data_in is 8'h00.
REQ-036 With reset held together with mem_req=1, no transaction SHALL start.

Verification
REQ-037 Read: addr=16'h1234, mem_req=1 read; SRAM model returns 8'hA5 -> MOSI stream 03 12 34, mem_ready at +65, mem_data_in=8'hA5.
REQ-038 Write: addr=16'hFFFF, data=8'h3C -> MOSI 02 FF FF 3C, 32 rising sclk, mem_ready at +65, mem_data_in unchanged.
REQ-039 Back-to-back: mem_req held high through two reads (16'h0000, 16'h0001 -> 8'h11, 8'h22) -> CS high exactly 2 clk between, both pulses correct.
REQ-040 Both strobes high, addr=16'h0010, data=8'h77 -> write command 02 issued.
REQ-041 Reset at SHIFT cycle 20 -> cs_n=1 next clk, no mem_ready, following read of 16'h0002 completes normally.
REQ-042 Address/data inputs randomized every cycle during SHIFT -> serialized bytes match the values latched at acceptance.

Source files
------------

// File: rtl/spi_mem_ctrl_if.sv
// CPU-side memory bus for spi_mem_ctrl: request level, direction strobes,
// address/write data toward the controller, ready pulse and read data back.
interface spi_mem_ctrl_if;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data_out;
   logic        mem_read;
   logic        mem_write;
   logic        mem_req;
   logic        mem_ready;
   logic [7:0]  mem_data_in;

   modport master (
      output mem_addr, mem_data_out, mem_read, mem_write, mem_req,
      input  mem_ready, mem_data_in
   );

   modport slave (
      input  mem_addr, mem_data_out, mem_read, mem_write, mem_req,
      output mem_ready, mem_data_in
   );
endinterface

// File: rtl/spi_mem_ctrl.sv
// SPI SRAM controller: turns one CPU byte access into a 32-bit mode-0 SPI
// frame (command, 16-bit address, data byte), SCLK = clk/2, MSB first.
module spi_mem_ctrl #(
   parameter logic [7:0] CMD_READ  = 8'h03,
   parameter logic [7:0] CMD_WRITE = 8'h02
) (
   input  logic           clk,
   input  logic           reset,
   spi_mem_ctrl_if.slave  bus,
   output logic           spi_cs_n,
   output logic           spi_sclk,
   output logic           spi_mosi,
   input  logic           spi_miso,
   output logic           busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e      state_q,   state_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic        phase_q,   phase_d;
   logic [31:0] sh_q,      sh_d;
   logic [7:0]  rx_q,      rx_d;
   logic        is_wr_q,   is_wr_d;
   logic        cs_n_q,    cs_n_d;
   logic        sclk_q,    sclk_d;
   logic        mosi_q,    mosi_d;
   logic        ready_q,   ready_d;
   logic [7:0]  data_in_q, data_in_d;
   logic        busy_q,    busy_d;
   logic [7:0]  cmd;

   // Next-state and next-output computation for the whole transaction.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      phase_d   = phase_q;
      sh_d      = sh_q;
      rx_d      = rx_q;
      is_wr_d   = is_wr_q;
      cs_n_d    = cs_n_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      ready_d   = 1'b0;
      data_in_d = data_in_q;
      cmd       = bus.mem_write ? CMD_WRITE : CMD_READ;

      case (state_q)
         IDLE: begin
            if (bus.mem_req) begin
               state_d   = SHIFT;
               is_wr_d   = bus.mem_write;
               // Read frames carry a zero data byte so MOSI idles low while
               // the SRAM drives MISO.
               sh_d      = {cmd, bus.mem_addr,
                            bus.mem_write ? bus.mem_data_out : 8'h00};
               mosi_d    = cmd[7];
               cs_n_d    = 1'b0;
               sclk_d    = 1'b0;
               bit_cnt_d = '0;
               phase_d   = 1'b0;
            end
         end
         SHIFT: begin
            if (!phase_q) begin
               sclk_d  = 1'b1;
               phase_d = 1'b1;
               if (!is_wr_q && (bit_cnt_q >= 5'd24))
                  rx_d = {rx_q[6:0], spi_miso};
            end else begin
               sclk_d  = 1'b0;
               phase_d = 1'b0;
               if (bit_cnt_q == 5'd31) begin
                  state_d = DONE;
                  cs_n_d  = 1'b1;
                  mosi_d  = 1'b0;
                  ready_d = 1'b1;
                  if (!is_wr_q)
                     data_in_d = rx_q;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  sh_d      = {sh_q[30:0], 1'b0};
                  mosi_d    = sh_q[30];
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; synchronous reset aborts any frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         phase_q   <= 1'b0;
         sh_q      <= '0;
         rx_q      <= '0;
         is_wr_q   <= 1'b0;
         cs_n_q    <= 1'b1;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         ready_q   <= 1'b0;
         data_in_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         phase_q   <= phase_d;
         sh_q      <= sh_d;
         rx_q      <= rx_d;
         is_wr_q   <= is_wr_d;
         cs_n_q    <= cs_n_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         ready_q   <= ready_d;
         data_in_q <= data_in_d;
         busy_q    <= busy_d;
      end
   end

   assign spi_cs_n        = cs_n_q;
   assign spi_sclk        = sclk_q;
   assign spi_mosi        = mosi_q;
   assign busy            = busy_q;
   assign bus.mem_ready   = ready_q;
   assign bus.mem_data_in = data_in_q;

endmodule
